// File: rtl/fpu_core_pkg.sv
// Shared types and constants for the fpu_core binary32 add/subtract coprocessor.
package pa_fpu;

    localparam int unsigned ExpW  = 8;
    localparam int unsigned FracW = 23;

    typedef enum logic [7:0] {
        op_add = 8'h00,
        op_sub = 8'h01
    } e_fpu_operations;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } e_fpu_state;

    localparam logic [3:0] AddrOpA0   = 4'h0;
    localparam logic [3:0] AddrOpB0   = 4'h4;
    localparam logic [3:0] AddrOpcode = 4'h8;
    localparam logic [3:0] AddrStart  = 4'h9;
    localparam logic [3:0] AddrRes0   = 4'h9;

    localparam logic [31:0] FpNan = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_addsub.sv
// Multi-cycle binary32 add/subtract datapath: align, add, one-bit-per-cycle normalize, RNE round.
module fpu_addsub
    import pa_fpu::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  e_fpu_state  state_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [7:0]  op_i,
    output logic        norm_done_o,
    output logic [31:0] result_o
);

    // hidden bit + fraction + guard/round/sticky
    localparam int unsigned ManW = FracW + 4;

    logic [ExpW-1:0] exp_a, exp_b, exp_big, exp_sml, shamt;
    logic [30:0]     mag_a, mag_b, mag_big, mag_sml;
    logic            sign_a, sign_b, swap, sign_big, sign_sml;
    logic [ManW-1:0] man_big, man_sml, man_shr, man_lost, man_aligned;

    logic [ManW-1:0]   big_q, sml_q;
    logic [ManW:0]     man_q, man_d;
    logic signed [9:0] exp_q, exp_d, exp_rnd;
    logic              sign_q, sub_q, nan_q, bad_q;
    logic              round_up;
    logic [FracW+1:0]  man_rnd;
    logic [FracW-1:0]  frac_rnd;

    always_comb begin
        exp_a    = a_i[FracW +: ExpW];
        exp_b    = b_i[FracW +: ExpW];
        mag_a    = (exp_a == '0) ? '0 : a_i[30:0];
        mag_b    = (exp_b == '0) ? '0 : b_i[30:0];
        sign_a   = a_i[31];
        sign_b   = b_i[31] ^ (op_i == op_sub);
        swap     = mag_b > mag_a;
        mag_big  = swap ? mag_b : mag_a;
        mag_sml  = swap ? mag_a : mag_b;
        sign_big = swap ? sign_b : sign_a;
        sign_sml = swap ? sign_a : sign_b;
        exp_big  = mag_big[FracW +: ExpW];
        exp_sml  = mag_sml[FracW +: ExpW];
        man_big  = {exp_big != '0, mag_big[FracW-1:0], 3'b000};
        man_sml  = {exp_sml != '0, mag_sml[FracW-1:0], 3'b000};
        shamt    = exp_big - exp_sml;
        // Bits shifted out collapse into the sticky bit.
        man_shr     = man_sml >> shamt;
        man_lost    = man_sml & ~({ManW{1'b1}} << shamt);
        man_aligned = man_shr | {{(ManW-1){1'b0}}, |man_lost};
    end

    assign norm_done_o = (man_q == '0) || (man_q[ManW -: 2] == 2'b01);

    always_comb begin
        man_d = man_q;
        exp_d = exp_q;
        case (state_i)
            StAlign: exp_d = {2'b00, exp_big};
            StAdd:   man_d = sub_q ? ({1'b0, big_q} - {1'b0, sml_q})
                                   : ({1'b0, big_q} + {1'b0, sml_q});
            StNorm: begin
                if (!norm_done_o) begin
                    if (man_q[ManW]) begin
                        man_d = {1'b0, man_q[ManW:2], man_q[1] | man_q[0]};
                        exp_d = exp_q + 10'sd1;
                    end else begin
                        man_d = {man_q[ManW-1:0], 1'b0};
                        exp_d = exp_q - 10'sd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        round_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
        man_rnd  = {1'b0, man_q[ManW-1:3]} + {{(FracW+1){1'b0}}, round_up};
        exp_rnd  = man_rnd[FracW+1] ? (exp_q + 10'sd1) : exp_q;
        frac_rnd = man_rnd[FracW+1] ? man_rnd[FracW:1] : man_rnd[FracW-1:0];
        if (bad_q) begin
            result_o = '0;
        end else if (nan_q) begin
            result_o = FpNan;
        end else if (man_q == '0) begin
            result_o = '0;
        end else if (exp_rnd >= 10'sd255) begin
            result_o = {sign_q, 8'hFF, 23'h0};
        end else if (exp_rnd <= 10'sd0) begin
            result_o = {sign_q, 31'h0};
        end else begin
            result_o = {sign_q, exp_rnd[ExpW-1:0], frac_rnd};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            big_q  <= '0;
            sml_q  <= '0;
            man_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            sub_q  <= 1'b0;
            nan_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            man_q <= man_d;
            exp_q <= exp_d;
            if (state_i == StAlign) begin
                big_q  <= man_big;
                sml_q  <= man_aligned;
                sign_q <= sign_big;
                sub_q  <= sign_big ^ sign_sml;
                nan_q  <= (exp_a == '1) || (exp_b == '1);
                bad_q  <= (op_i != op_add) && (op_i != op_sub);
            end
        end
    end

endmodule

// File: rtl/fpu_core.sv
// Byte-wide bus slave wrapping the fpu_addsub datapath: register file, start detect, FSM, handshake.
module fpu_core
    import pa_fpu::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] databus_in,
    output logic [7:0] databus_out,
    input  logic [3:0] addr,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       end_ack,
    output logic       cmd_end,
    output logic       busy
);

    e_fpu_state  state_q, state_d;
    logic [31:0] opa_q, opb_q, result_q, dp_result;
    logic [7:0]  opcode_q;
    logic        wr_q, start_q, norm_done, wr_en, start_pulse;
    logic [3:0]  rd_idx;

    assign wr_en       = !cs && !wr && (state_q == StIdle);
    assign start_pulse = wr_en && wr_q && (addr == AddrStart);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            opcode_q <= '0;
            result_q <= '0;
            wr_q     <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            wr_q    <= wr;
            start_q <= start_pulse;
            if (wr_en && addr[3:2] == AddrOpA0[3:2]) begin
                opa_q[{addr[1:0], 3'b000} +: 8] <= databus_in;
            end
            if (wr_en && addr[3:2] == AddrOpB0[3:2]) begin
                opb_q[{addr[1:0], 3'b000} +: 8] <= databus_in;
            end
            if (wr_en && addr == AddrOpcode) begin
                opcode_q <= databus_in;
            end
            if (state_q == StRound) begin
                result_q <= dp_result;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_q) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  if (norm_done) state_d = StRound;
            StRound: state_d = StDone;
            StDone:  if (end_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = (state_q == StAlign) || (state_q == StAdd) ||
                  (state_q == StNorm) || (state_q == StRound);
        cmd_end = (state_q == StDone);
    end

    // Result bytes sit at 0x9..0xC; any other address wraps out of range.
    always_comb begin
        rd_idx      = addr - AddrRes0;
        databus_out = 8'h00;
        if (!cs && !rd && rd_idx < 4'd4) begin
            databus_out = result_q[{rd_idx[1:0], 3'b000} +: 8];
        end
    end

    fpu_addsub u_addsub (
        .clk_i       (clk),
        .rst_ni      (arst),
        .state_i     (state_q),
        .a_i         (opa_q),
        .b_i         (opb_q),
        .op_i        (opcode_q),
        .norm_done_o (norm_done),
        .result_o    (dp_result)
    );

endmodule

// File: tb/tb_fpu_core.sv
// Directed and randomized checks of fpu_core against an exact-arithmetic binary32 reference.
module tb_fpu_core;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] databus_in = 8'h00;
    logic [7:0] databus_out;
    logic [3:0] addr = 4'h0;
    logic       cs = 1'b1;
    logic       rd = 1'b1;
    logic       wr = 1'b1;
    logic       end_ack = 1'b0;
    logic       cmd_end;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int          ea, eb, dexp, extra;
    logic [31:0] ra, rb, rt, res;
    logic [7:0]  rop, rbyte;

    always #5 clk = ~clk;

    fpu_core dut (
        .clk         (clk),
        .arst        (arst),
        .databus_in  (databus_in),
        .databus_out (databus_out),
        .addr        (addr),
        .cs          (cs),
        .rd          (rd),
        .wr          (wr),
        .end_ack     (end_ack),
        .cmd_end     (cmd_end),
        .busy        (busy)
    );

    // Exact sum of the two flushed operands, then a single RNE rounding to 24 bits.
    function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [7:0] op);
        int          fa, fb, elo, sh, p;
        longint      ma, mb, va, vb, s, mag, keep, rem, half;
        logic        sa, sb, neg;
        logic [31:0] hi;
        if (op > 8'h01) return 32'h0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        fa = int'(a[30:23]);
        fb = int'(b[30:23]);
        ma = (fa == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
        mb = (fb == 0) ? 64'd0 : longint'({1'b1, b[22:0]});
        sa = a[31];
        sb = b[31] ^ op[0];
        if (fa >= fb) begin
            elo = fb;
            hi  = {sa, a[30:0]};
            if (fa - fb > 30) return hi;
        end else begin
            elo = fa;
            hi  = {sb, b[30:0]};
            if (fb - fa > 30) return hi;
        end
        va = ma << (fa - elo);
        vb = mb << (fb - elo);
        if (sa) va = -va;
        if (sb) vb = -vb;
        s = va + vb;
        if (s == 0) return 32'h0;
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 62; i++) if ((mag >> i) != 0) p = i;
        if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag - (keep << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == (longint'(1) << 24)) begin
                keep = keep >> 1;
                sh   = sh + 1;
            end
        end else begin
            sh   = p - 23;
            keep = mag << (23 - p);
        end
        if (elo + sh >= 255) return {neg, 8'hFF, 23'h0};
        if (elo + sh <= 0) return {neg, 31'h0};
        return {neg, 8'(elo + sh), keep[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = a; databus_in = d;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1;
    endtask

    task automatic write_word(input logic [3:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_write(base + 4'(i), w[8*i +: 8]);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = a;
        #1 d = databus_out;
        #1 cs = 1'b1; rd = 1'b1;
    endtask

    task automatic read_result(output logic [31:0] r);
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(9 + i), d);
            r[8*i +: 8] = d;
        end
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        write_word(4'h0, a);
        write_word(4'h4, b);
        bus_write(4'h8, op);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (cmd_end) break;
            @(negedge clk);
        end
        check(tag, 32'(cmd_end), 32'd1);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        end_ack = 1'b1;
        @(negedge clk);
        end_ack = 1'b0;
        check(tag, 32'(cmd_end), 32'd0);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] expv);
        logic [31:0] r;
        wait_done({tag, "_done"});
        check({tag, "_busy"}, 32'(busy), 32'd0);
        read_result(r);
        check(tag, r, expv);
        do_ack({tag, "_ack"});
        read_result(r);
        check({tag, "_reread"}, r, expv);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] op, input logic [31:0] expv);
        load_ops(a, b, op);
        bus_write(4'h9, 8'h00);
        finish_op(tag, expv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_end", 32'(cmd_end), 32'd0);
        bus_read(4'h9, rbyte);
        check("rst_dbus", 32'(rbyte), 32'd0);
        @(negedge clk);
        arst = 1'b1;
        read_result(res);
        check("rst_result", res, 32'h0);

        // Reference vectors, with cmd_end held until acknowledged
        load_ops(32'h4A96_890D, 32'h4A44_7FAD, 8'h01);
        bus_write(4'h9, 8'h00);
        wait_done("sub_done");
        repeat (3) @(negedge clk);
        check("sub_hold", 32'(cmd_end), 32'd1);
        bus_read(4'h9, rbyte);
        check("sub_byte0", 32'(rbyte), 32'hDA);
        bus_read(4'hC, rbyte);
        check("sub_byte3", 32'(rbyte), 32'h49);
        bus_read(4'hD, rbyte);
        check("unmapped_rd", 32'(rbyte), 32'h00);
        finish_op("sub", 32'h49D1_24DA);
        run_op("add_tie", 32'h4A96_890D, 32'h4A44_7FAD, 8'h00, 32'h4AF8_C8E4);
        run_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 8'h00, 32'h4000_0000);
        run_op("pi_minus_pi", 32'h4049_0FDB, 32'h4049_0FDB, 8'h01, 32'h0000_0000);

        // Boundaries
        run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 8'h00, 32'h7F80_0000);
        run_op("nan_in", 32'h7F80_0000, 32'h3F80_0000, 8'h00, 32'h7FC0_0000);
        run_op("denorm_flush", 32'h0040_0000, 32'h3F80_0000, 8'h00, 32'h3F80_0000);
        run_op("underflow", 32'h0080_0001, 32'h0080_0000, 8'h01, 32'h0000_0000);
        run_op("bad_opcode", 32'h3F80_0000, 32'h3F80_0000, 8'h7F, 32'h0000_0000);

        // Start and operand writes while busy are ignored
        load_ops(32'h3F80_0000, 32'h3F80_0000, 8'h00);
        bus_write(4'h9, 8'h00);
        bus_write(4'h0, 8'h55);
        bus_write(4'h9, 8'h00);
        check("busy_mid_op", 32'(busy), 32'd1);
        finish_op("busy_ignore", 32'h4000_0000);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || cmd_end) extra++;
        end
        check("busy_no_restart", 32'(extra), 32'd0);

        // Held strobe starts one operation; operand A must still be 1.0
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 4'h9;
        repeat (3) @(negedge clk);
        cs = 1'b1; wr = 1'b1;
        finish_op("held_wr", 32'h4000_0000);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || cmd_end) extra++;
        end
        check("held_wr_single", 32'(extra), 32'd0);

        // Randomized operands against the reference model
        for (int n = 0; n < 40; n++) begin
            ea   = int'($urandom_range(190, 60));
            dexp = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(32, 0));
            eb   = ea - dexp;
            ra   = {1'($urandom_range(1, 0)), 8'(ea), 23'($urandom)};
            rb   = {1'($urandom_range(1, 0)), 8'(eb), 23'($urandom)};
            if ($urandom_range(3, 0) == 0) rb[22:6] = ra[22:6];
            if ($urandom_range(1, 0) == 1) begin
                rt = ra; ra = rb; rb = rt;
            end
            rop = 8'($urandom_range(1, 0));
            run_op("rand", ra, rb, rop, ref_fp(ra, rb, rop));
        end

        // Reset in the middle of an operation
        run_op("pre_reset", 32'h4A96_890D, 32'h4A44_7FAD, 8'h00, 32'h4AF8_C8E4);
        load_ops(32'h4049_0FDB, 32'h3F80_0000, 8'h00);
        bus_write(4'h9, 8'h00);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 arst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_end", 32'(cmd_end), 32'd0);
        read_result(res);
        check("mid_rst_result", res, 32'h0);
        @(negedge clk);
        arst = 1'b1;
        run_op("post_reset", 32'h4049_0FDB, 32'h3F80_0000, 8'h00,
               ref_fp(32'h4049_0FDB, 32'h3F80_0000, 8'h00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
